pll_cfg_seq: RTL



---
 rtl/pll_cfg_seq.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pll_cfg_seq.sv
// -----------------------------------------------------------------------------
// pll_cfg_seq
//
// PLL reconfiguration sequencer in the CLK domain. It accepts one request at
// a time over a valid/ready handshake and drives the PLL_ADDR/PLL_CHG pair of
// the downstream PLL control stage with exactly one change strobe per request.
// After the strobe it ignores lock for a hold-off window, then waits until the
// synchronized lock has been high for STABLE consecutive cycles before it
// reports completion. A request for the address that is already active is
// skipped: it completes at once and does not touch the PLL.
//
// Optional feature macro: PLL_CFG_TIMEOUT_EN
//   defined   - a WAIT_LOCK cycle counter aborts after TIMEOUT cycles, sets the
//               sticky ERR flag and invalidates the active address
//   undefined - no timeout, ERR is tied low, WAIT_LOCK waits indefinitely
//
// Parameters
//   HOLDOFF  cycles after PLL_CHG during which lock is ignored (1..2^CW-1)
//   STABLE   consecutive lock-high cycles required for completion (1..2^CW-1)
//   TIMEOUT  maximum WAIT_LOCK cycles before error (1..2^CW-1)
//   CW       width of the internal counters
//
// Ports
//   CLK        in   system clock, also the PLL DRP clock
//   RSTXO      in   asynchronous active-low reset
//   REQ_VALID  in   request present
//   REQ_ADDR   in   [7:0] requested PLL configuration address
//   REQ_READY  out  high only in IDLE (decoded from state)
//   LOCK_IN    in   raw PLL lock, asynchronous to CLK
//   PLL_ADDR   out  [7:0] registered address to PLL control
//   PLL_CHG    out  registered one-cycle change strobe
//   BUSY       out  high in every state except IDLE
//   DONE       out  one-cycle completion pulse
//   ERR        out  sticky lock-timeout flag
//   CUR_ADDR   out  [7:0] last successfully applied address
// -----------------------------------------------------------------------------
module pll_cfg_seq #(
   parameter int HOLDOFF = 64,
   parameter int STABLE  = 16,
   parameter int TIMEOUT = 65535,
   parameter int CW      = 16
) (
   input  logic       CLK,
   input  logic       RSTXO,
   input  logic       REQ_VALID,
   input  logic [7:0] REQ_ADDR,
   output logic       REQ_READY,
   input  logic       LOCK_IN,
   output logic [7:0] PLL_ADDR,
   output logic       PLL_CHG,
   output logic       BUSY,
   output logic       DONE,
   output logic       ERR,
   output logic [7:0] CUR_ADDR
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_HOLD  = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};
   // HOLD is entered with HOLDOFF-1 and left when the counter reads zero,
   // which gives exactly HOLDOFF cycles in that state.
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF - 1);
   localparam logic [CW-1:0] STABLE_C  = CW'(STABLE);

   // Zero or out-of-range parameters would make a window vanish or wrap.
   if (HOLDOFF < 1 || STABLE < 1 || TIMEOUT < 1 || CW < 2 || CW > 30 ||
       HOLDOFF > (2**CW) - 1 || STABLE > (2**CW) - 1 ||
       TIMEOUT > (2**CW) - 1) begin : g_bad_param
      $error("pll_cfg_seq: illegal parameter value");
   end

   // Saturating increment: counters stop at all-ones instead of wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + ONE_C;
      end
   endfunction

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;        // hold-off down-counter, then stable up-counter
   logic [CW-1:0] w_cnt_nxt;
   logic [CW-1:0] w_stable_inc;
   logic          r_lock_meta;
   logic          r_lock_s;
   logic [7:0]    r_pll_addr;
   logic          r_pll_chg;
   logic          r_busy;
   logic          r_done;
   logic [7:0]    r_cur_addr;
   logic          r_cur_valid;
   logic          w_capture;    // non-skip acceptance this cycle
   logic          w_complete;   // lock stable, address becomes active
   logic          w_timeout;    // WAIT_LOCK gave up

`ifdef PLL_CFG_TIMEOUT_EN
   localparam logic [CW-1:0] TMO_C = CW'(TIMEOUT);
   logic [CW-1:0] r_tmo;
   logic [CW-1:0] w_tmo_nxt;
   logic [CW-1:0] w_tmo_inc;
   logic          r_err;
   assign w_tmo_inc = sat_inc(r_tmo);
`endif

   assign w_stable_inc = sat_inc(r_cnt);

   // Next-state, counter and event decode for the sequencer FSM.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      w_complete  = 1'b0;
      w_timeout   = 1'b0;
`ifdef PLL_CFG_TIMEOUT_EN
      w_tmo_nxt   = r_tmo;
`endif
      case (r_state)
         S_IDLE: begin
            if (REQ_VALID) begin
               if (r_cur_valid && (REQ_ADDR == r_cur_addr)) begin
                  // Already active: report completion without a PLL write.
                  w_state_nxt = S_DONE;
               end else begin
                  w_capture   = 1'b1;
                  w_state_nxt = S_ISSUE;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ISSUE: begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = HOLD_LOAD;
         end
         S_HOLD: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = '0;
`ifdef PLL_CFG_TIMEOUT_EN
               w_tmo_nxt   = '0;
`endif
            end else begin
               w_cnt_nxt = r_cnt - ONE_C;
            end
         end
         S_WAIT: begin
            // Any low cycle restarts the run of consecutive lock-high cycles.
            if (r_lock_s) begin
               w_cnt_nxt = w_stable_inc;
               if (w_stable_inc == STABLE_C) begin
                  w_complete  = 1'b1;
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end else begin
               w_cnt_nxt = '0;
            end
`ifdef PLL_CFG_TIMEOUT_EN
            // Lock reaching stability in the final allowed cycle still wins.
            w_tmo_nxt = w_tmo_inc;
            if (!w_complete && (w_tmo_inc == TMO_C)) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_timeout   = 1'b0;
            end
`endif
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // State and shared counter registers.
   always_ff @(posedge CLK or negedge RSTXO) begin
      if (!RSTXO) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Two-flop synchronizer for the asynchronous PLL lock.
   always_ff @(posedge CLK or negedge RSTXO) begin
      if (!RSTXO) begin
         r_lock_meta <= 1'b0;
         r_lock_s    <= 1'b0;
      end else begin
         r_lock_meta <= LOCK_IN;
         r_lock_s    <= r_lock_meta;
      end
   end

   // Registered outputs, decoded from the next state so they line up with it.
   always_ff @(posedge CLK or negedge RSTXO) begin
      if (!RSTXO) begin
         r_pll_addr  <= 8'h00;
         r_pll_chg   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_cur_addr  <= 8'h00;
         r_cur_valid <= 1'b0;
      end else begin
         r_pll_chg <= w_capture;
         r_busy    <= (w_state_nxt != S_IDLE);
         r_done    <= (w_state_nxt == S_DONE);
         if (w_capture) begin
            r_pll_addr <= REQ_ADDR;
         end
         if (w_complete) begin
            r_cur_addr  <= r_pll_addr;
            r_cur_valid <= 1'b1;
         end else if (w_timeout) begin
            // Force a retry of the same address to reprogram the PLL.
            r_cur_valid <= 1'b0;
         end
      end
   end

`ifdef PLL_CFG_TIMEOUT_EN
   // Timeout counter and sticky error flag.
   always_ff @(posedge CLK or negedge RSTXO) begin
      if (!RSTXO) begin
         r_tmo <= '0;
         r_err <= 1'b0;
      end else begin
         r_tmo <= w_tmo_nxt;
         if (w_capture) begin
            r_err <= 1'b0;
         end else if (w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end
   assign ERR = r_err;
`else
   assign ERR = 1'b0;
`endif

   assign REQ_READY = (r_state == S_IDLE);
   assign PLL_ADDR  = r_pll_addr;
   assign PLL_CHG   = r_pll_chg;
   assign BUSY      = r_busy;
   assign DONE      = r_done;
   assign CUR_ADDR  = r_cur_addr;

endmodule
